// File: rtl/plru_alloc_arb.sv
// plru_alloc_arb: allocation arbiter, lowest free entry first, else tree-PLRU victim avoiding locked entries
module plru_alloc_arb #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_rdy,
    output logic [WIDTH-1:0] alloc_gnt,
    output logic [IDXW-1:0]  alloc_idx,
    output logic             alloc_evict,
    input  logic             touch_en,
    input  logic [WIDTH-1:0] touch_vec,
    input  logic             free_en,
    input  logic [WIDTH-1:0] free_vec,
    input  logic [WIDTH-1:0] lock_mask,
    output logic [WIDTH-1:0] valid_vec,
    output logic             full
);
    logic [WIDTH-2:0] node, node_nxt;
    logic [WIDTH-1:0] valid, valid_nxt, cand;
    logic             fire;
    int               low, cur, nxt, sel;
    logic             r;

    function automatic logic [WIDTH-1:0] half_mask(input int k, input logic right);
        int d, span, lo;
        d = 0;
        for (int i = 1; i < IDXW; i++) if (k >= (1 << i) - 1) d = i;
        span = WIDTH >> d;
        lo = (k + 1 - (1 << d)) * span + (right ? span / 2 : 0);
        half_mask = '0;
        for (int j = 0; j < WIDTH; j++) half_mask[j] = (j >= lo) && (j < lo + span / 2);
    endfunction

    function automatic logic [WIDTH-2:0] plru_upd(input logic [WIDTH-2:0] n, input logic [WIDTH-1:0] a);
        plru_upd = n;
        for (int k = 0; k < WIDTH - 1; k++)
            plru_upd[k] = (n[k] | |(a & half_mask(k, 1'b0))) & ~|(a & half_mask(k, 1'b1));
    endfunction

    // choose lowest free unlocked entry, otherwise walk the tree steering around fully locked subtrees
    always_comb begin
        cand = ~valid & ~lock_mask;
        low = 0;
        for (int j = WIDTH - 1; j >= 0; j--) if (cand[j]) low = j;
        cur = 0;
        r = 1'b0;
        for (int l = 0; l < IDXW; l++) begin
            nxt = 0;
            for (int k = 0; k < WIDTH - 1; k++) begin
                if (k == cur) begin
                    r = node[k] ^ ~|(half_mask(k, node[k]) & ~lock_mask);
                    nxt = 2 * k + 1 + (r ? 1 : 0);
                end
            end
            cur = nxt;
        end
        sel = |cand ? low : cur - (WIDTH - 1);
        alloc_rdy = ~&lock_mask;
        alloc_idx = alloc_rdy ? IDXW'(sel) : '0;
        alloc_gnt = alloc_rdy ? {{(WIDTH-1){1'b0}}, 1'b1} << alloc_idx : '0;
        alloc_evict = alloc_rdy & valid[alloc_idx];
    end

    // touch update first, then the allocated entry becomes most recent; fire overrides free
    always_comb begin
        fire = alloc_req & alloc_rdy;
        node_nxt = node;
        if (touch_en) node_nxt = plru_upd(node_nxt, touch_vec);
        if (fire) node_nxt = plru_upd(node_nxt, alloc_gnt);
        valid_nxt = (valid & ~(free_en ? free_vec : '0)) | (fire ? alloc_gnt : '0);
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            node  <= '0;
            valid <= '0;
        end else begin
            node  <= node_nxt;
            valid <= valid_nxt;
        end
    end

    assign valid_vec = valid;
    assign full      = &valid;
endmodule

// File: tb/tb_plru_alloc_arb.sv
// tb_plru_alloc_arb: directed and random checks against a path-based PLRU reference model
module tb_plru_alloc_arb;
    localparam int W  = 4;
    localparam int IW = 2;

    logic          clk, rst, alloc_req, alloc_rdy, alloc_evict, touch_en, free_en, full;
    logic [W-1:0]  alloc_gnt, touch_vec, free_vec, lock_mask, valid_vec;
    logic [IW-1:0] alloc_idx;

    int errs = 0;
    int checks = 0;

    bit         mnode [W-1];
    bit [W-1:0] mval;

    plru_alloc_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_rdy(alloc_rdy),
        .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .alloc_evict(alloc_evict),
        .touch_en(touch_en), .touch_vec(touch_vec), .free_en(free_en),
        .free_vec(free_vec), .lock_mask(lock_mask), .valid_vec(valid_vec), .full(full)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        mval = '0;
        for (int k = 0; k < W - 1; k++) mnode[k] = 0;
    endfunction

    // entry index chosen by the reference, -1 when everything is locked
    function automatic int m_pick(input bit [W-1:0] lm);
        bit [W-1:0] cand;
        int e, k, c;
        bit ok;
        cand = ~mval & ~lm;
        if (&lm) return -1;
        for (int j = 0; j < W; j++) if (cand[j]) return j;
        e = 0;
        for (int d = 0; d < IW; d++) begin
            k = (1 << d) - 1 + e;
            c = 2 * e + int'(mnode[k]);
            ok = 0;
            for (int j = 0; j < W; j++) if ((j >> (IW - d - 1)) == c && !lm[j]) ok = 1;
            if (!ok) c = 2 * e + 1 - int'(mnode[k]);
            e = c;
        end
        return e;
    endfunction

    // mark the path to an entry so every node points away from it
    function automatic void m_touch(input int ent);
        for (int d = 0; d < IW; d++)
            mnode[(1 << d) - 1 + (ent >> (IW - d))] = ((ent >> (IW - 1 - d)) & 1) == 0;
    endfunction

    task automatic peek(input logic [W-1:0] lm, input logic [W-1:0] exp, input string tag);
        rst = 0; alloc_req = 0; touch_en = 0; touch_vec = '0; free_en = 0; free_vec = '0;
        lock_mask = lm;
        #1;
        chk(tag, alloc_gnt, exp);
    endtask

    task automatic cyc(input logic r, q, te, input logic [W-1:0] tv, input logic fe,
                       input logic [W-1:0] fv, lm);
        int p, t;
        logic [W-1:0] eg;
        rst = r; alloc_req = q; touch_en = te; touch_vec = tv; free_en = fe; free_vec = fv;
        lock_mask = lm;
        assert (!te || $onehot0(tv)) else $error("illegal multi-hot touch_vec %b", tv);
        #1;
        p = m_pick(lm);
        eg = (p < 0) ? '0 : W'(1) << p;
        chk("rdy", alloc_rdy, p >= 0);
        chk("gnt", alloc_gnt, eg);
        chk("idx", alloc_idx, (p < 0) ? 0 : p);
        chk("evict", alloc_evict, p >= 0 && mval[p]);
        chk("valid", valid_vec, mval);
        chk("full", full, &mval);
        @(posedge clk);
        if (r) m_reset();
        else begin
            t = -1;
            for (int j = 0; j < W; j++) if (tv[j]) t = j;
            if (te && t >= 0) m_touch(t);
            if (q && p >= 0) m_touch(p);
            mval = mval & ~(fe ? fv : '0);
            if (q && p >= 0) mval[p] = 1;
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] tv, lm;
        rst = 1; alloc_req = 0; touch_en = 0; touch_vec = '0; free_en = 0; free_vec = '0; lock_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        peek(4'b0000, 4'b0001, "rst_gnt");
        chk("rst_idx", alloc_idx, 0);
        chk("rst_evict", alloc_evict, 0);
        chk("rst_full", full, 0);
        chk("rst_rdy", alloc_rdy, 1);
        for (int i = 0; i < 4; i++) begin
            peek(4'b0000, 4'b0001 << i, "fill_gnt");
            chk("fill_evict", alloc_evict, 0);
            cyc(0, 1, 0, '0, 0, '0, '0);
        end
        chk("fill_full", full, 1);
        peek(4'b0000, 4'b0001, "victim_gnt");
        chk("victim_evict", alloc_evict, 1);
        cyc(0, 1, 0, '0, 0, '0, '0);
        cyc(0, 0, 1, 4'b0010, 0, '0, '0);
        peek(4'b0000, 4'b0100, "touch1_gnt");
        cyc(0, 0, 1, 4'b1000, 0, '0, '0);
        cyc(0, 0, 1, 4'b0001, 0, '0, '0);
        peek(4'b0000, 4'b0100, "touch0_gnt");
        peek(4'b0100, 4'b1000, "lock2_gnt");
        peek(4'b1100, 4'b0010, "lock23_gnt");
        peek(4'b1111, 4'b0000, "lockall_gnt");
        chk("lockall_rdy", alloc_rdy, 0);
        cyc(0, 1, 0, '0, 0, '0, 4'b1111);
        chk("lockall_valid", valid_vec, 4'b1111);
        peek(4'b0000, 4'b0100, "lockall_node");
        cyc(0, 0, 0, '0, 1, 4'b1010, '0);
        peek(4'b0000, 4'b0010, "free_gnt");
        chk("free_evict", alloc_evict, 0);
        peek(4'b1010, 4'b0100, "fire2_gnt");
        cyc(0, 1, 0, '0, 1, 4'b0100, 4'b1010);
        chk("fire_beats_free", valid_vec, 4'b0101);
        cyc(1, 1, 1, 4'b0010, 0, '0, '0);
        peek(4'b0000, 4'b0001, "rst_mid_gnt");
        chk("rst_mid_valid", valid_vec, 0);
        chk("rst_mid_full", full, 0);
        for (int n = 0; n < 400; n++) begin
            tv = '0;
            tv[$urandom_range(0, W - 1)] = 1'b1;
            lm = ($urandom_range(0, 19) == 0) ? '1 : W'($urandom & $urandom & $urandom);
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, tv,
                $urandom_range(0, 4) == 0, W'($urandom), lm);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
